dsp_mem_stage: RTL
==================

# dsp_mem_stage

Parametrised memory stage of the DSP receiver pipeline: takes one ALU-stage operation per cycle, decodes its memory mode, drives NBANKS single-ported synchronous-read memory banks, and returns the write-back word one cycle later. It is the successor to the fixed two-bank combinational memory logic, adding configurable width, depth and bank count, registered load return, valid/ready flow control with downstream stall holding, and a sticky illegal-mode flag. It sits between the execute stage and register-file write-back.

## Interface
- ADDR_W, 8: full memory address width; the top log2(NBANKS) bits select the bank.
- DATA_W, 16: data word width.
- NBANKS, 2: bank count, a power of two, from 2 to 8.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operation present.
- in_ready  out  1  stage can accept.
- mem_mode  in  3  0 MEM_NONE, 1 MEM_LD, 2 MEM_ST, 3 MEM_LD_IMM, 4–7 illegal.
- read_addr  in  ADDR_W  load address.
- write_addr  in  ADDR_W  store address.
- alu_result  in  DATA_W  ALU result and store data.
- bank_addr  out  NBANKS*(ADDR_W-log2 NBANKS)  per-bank local address.
- bank_rd_en  out  NBANKS  per-bank read strobe.
- bank_wr_en  out  NBANKS  per-bank write strobe.
- bank_wdata  out  DATA_W  shared write data.
- bank_rdata  in  NBANKS*DATA_W  per-bank read data, valid the cycle after bank_rd_en.
- wb_valid  out  1  write_back is valid.
- wb_ready  in  1  write-back consumer accepts.
- write_back  out  DATA_W  result.
- illegal_mode  out  1  sticky; set when an illegal mode is accepted.

## Operation
- Accept when in_valid && in_ready; in_ready = !s2_valid || wb_ready, so the stage sustains one operation per cycle.
- Issue (combinational, only on accept; all strobes are 0 otherwise):
  - MEM_LD: bank_rd_en[sel(read_addr)] = 1 and that bank's bank_addr = local(read_addr).
  - MEM_ST: bank_wr_en[sel(write_addr)] = 1, bank_wdata = alu_result.
  - MEM_NONE and MEM_LD_IMM: no bank access.
  - 4–7: no bank access; treated as MEM_NONE; sets illegal_mode.
- Result register (S2), captured on accept: s2_valid, is_load, bank_sel, and alu_result.
- write_back:
  - Load, first cycle in S2: bank_rdata of the captured bank_sel.
  - Load, later cycles: the hold register, which captures that rdata at the end of the first S2 cycle whenever wb_ready = 0.
  - Non-load: the captured alu_result.
- Store write-back carries alu_result; it is a pass-through tag for the register file.
- Unused bank_addr lanes: 0.
- Reset values: in_ready 1 (combinational), wb_valid 0, write_back 0, illegal_mode 0, all strobes 0, hold register 0.
- Reset mid-operation: the in-flight S2 operation is discarded, with no write-back.
- Strobes are forced to 0 while rst is high.

## Timing
- Accept at edge t, with strobes asserted in cycle t-1→t. wb_valid rises in the cycle after edge t, so latency is 1 cycle for every mode.
- Stall: wb_valid and write_back are held stable until wb_ready. in_ready stays 0 while s2_valid && !wb_ready.
- A load accepted in the same cycle that S2 drains (wb_ready = 1) is legal; this gives back-to-back throughput.
- A store at edge t followed by a load of the same address at edge t+1 returns the new data. The banks are written at the edge, so no hazard logic is required.

## Configuration
- DSP_MEM_PERF_EN defined: adds outputs perf_loads, perf_stores and perf_stalls (16 bits each, saturating at 0xFFFF, reset to 0).
  - perf_loads and perf_stores increment on accepted MEM_LD and MEM_ST.
  - perf_stalls increments on each cycle with wb_valid && !wb_ready.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- The shared DSP package holds the MEM_NONE/MEM_LD/MEM_ST/MEM_LD_IMM encodings, the mode width (3), and the default ADDR_W and DATA_W.
- One sub-module, dsp_mem_bank_decode: combinational address-to-bank-select, local-address split, and one-hot strobe generation. It is instantiated once.

## Test plan
- Reset with in_valid = 1 and mode MEM_ST → no bank_wr_en asserted; wb_valid 0; write_back 0x0000; illegal_mode 0.
- MEM_ST write_addr 0x85, alu_result 0xBEEF (NBANKS 2), then MEM_LD read_addr 0x85 next cycle → bank_wr_en = 2'b10 with local addr 0x05; then bank_rd_en = 2'b10; write_back 0xBEEF one cycle after the load is accepted.
- MEM_NONE alu_result 0x1234 with wb_ready held 0 for 3 cycles → wb_valid 1 with 0x1234 stable for all 3 cycles; in_ready 0; one transfer when wb_ready goes to 1.
- Load from bank 0 returning 0x00A5 with wb_ready 0 for 2 cycles, while the model drives bank_rdata to 0xFFFF after the first S2 cycle → write_back stays 0x00A5 (hold register).
- Mode 3'b110 accepted → no strobes; write_back = alu_result; illegal_mode 1 and stays 1 until rst.
- With DSP_MEM_PERF_EN: 70000 accepted loads → perf_loads saturates at 0xFFFF; rst returns it to 0.

Source files
------------

// File: rtl/dsp_mem_stage_pkg.sv
// Shared DSP memory-stage definitions: memory-mode encodings, mode width
// and the default address/data widths.
package dsp_mem_stage_pkg;

    localparam int MODE_W     = 3;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [MODE_W-1:0] {
        MEM_NONE   = 3'd0,
        MEM_LD     = 3'd1,
        MEM_ST     = 3'd2,
        MEM_LD_IMM = 3'd3
    } mem_mode_e;

    // Encodings 4-7 are reserved; they behave as MEM_NONE but get flagged.
    function automatic logic is_illegal(input logic [MODE_W-1:0] mode);
        return mode[MODE_W-1];
    endfunction

endpackage

// File: rtl/dsp_mem_bank_decode.sv
// Address-to-bank decode: splits addresses into bank select and local address
// and generates the one-hot per-bank read/write strobes.
module dsp_mem_bank_decode
    import dsp_mem_stage_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NBANKS = 2,
    localparam int SEL_W = $clog2(NBANKS),
    localparam int LOC_W = ADDR_W - SEL_W
) (
    input  logic                    issue,
    input  logic [MODE_W-1:0]       mode,
    input  logic [ADDR_W-1:0]       read_addr,
    input  logic [ADDR_W-1:0]       write_addr,
    output logic [SEL_W-1:0]        read_sel,
    output logic [NBANKS*LOC_W-1:0] bank_addr,
    output logic [NBANKS-1:0]       bank_rd_en,
    output logic [NBANKS-1:0]       bank_wr_en
);

    logic [SEL_W-1:0] write_sel;

    assign read_sel  = read_addr[ADDR_W-1 -: SEL_W];
    assign write_sel = write_addr[ADDR_W-1 -: SEL_W];

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        bank_addr  = '0;
        bank_rd_en = '0;
        bank_wr_en = '0;
        if (issue) begin
            case (mode)
                MEM_LD: begin
                    bank_rd_en[read_sel]                 = 1'b1;
                    bank_addr[read_sel*LOC_W +: LOC_W]   = read_addr[LOC_W-1:0];
                end
                MEM_ST: begin
                    bank_wr_en[write_sel]                = 1'b1;
                    bank_addr[write_sel*LOC_W +: LOC_W]  = write_addr[LOC_W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dsp_mem_stage.sv
// DSP receiver memory stage: issues bank accesses and returns the write-back
// word one cycle later. Optional counters enabled by `define DSP_MEM_PERF_EN.
module dsp_mem_stage
    import dsp_mem_stage_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NBANKS = 2,
    localparam int SEL_W = $clog2(NBANKS),
    localparam int LOC_W = ADDR_W - SEL_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [MODE_W-1:0]        mem_mode,
    input  logic [ADDR_W-1:0]        read_addr,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic [DATA_W-1:0]        alu_result,
    output logic [NBANKS*LOC_W-1:0]  bank_addr,
    output logic [NBANKS-1:0]        bank_rd_en,
    output logic [NBANKS-1:0]        bank_wr_en,
    output logic [DATA_W-1:0]        bank_wdata,
    input  logic [NBANKS*DATA_W-1:0] bank_rdata,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [DATA_W-1:0]        write_back,
`ifdef DSP_MEM_PERF_EN
    output logic [15:0]              perf_loads,
    output logic [15:0]              perf_stores,
    output logic [15:0]              perf_stalls,
`endif
    output logic                     illegal_mode
);

    logic              accept;
    logic [SEL_W-1:0]  read_sel;
    logic              s2_valid;
    logic              s2_load;
    logic              s2_first;
    logic [SEL_W-1:0]  s2_sel;
    logic [DATA_W-1:0] s2_alu;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] rdata_sel;

    assign in_ready   = !s2_valid || wb_ready;
    assign accept     = in_valid && in_ready;
    assign bank_wdata = alu_result;

    dsp_mem_bank_decode #(
        .ADDR_W (ADDR_W),
        .NBANKS (NBANKS)
    ) u_decode (
        .issue      (accept && !rst),
        .mode       (mem_mode),
        .read_addr  (read_addr),
        .write_addr (write_addr),
        .read_sel   (read_sel),
        .bank_addr  (bank_addr),
        .bank_rd_en (bank_rd_en),
        .bank_wr_en (bank_wr_en)
    );

    assign rdata_sel = bank_rdata[s2_sel*DATA_W +: DATA_W];

    // Bank data is only valid for one cycle, so stalled loads read the hold copy.
    assign wb_valid   = s2_valid;
    assign write_back = !s2_valid ? '0 :
                        !s2_load  ? s2_alu :
                        s2_first  ? rdata_sel : hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            s2_load      <= 1'b0;
            s2_first     <= 1'b0;
            s2_sel       <= '0;
            s2_alu       <= '0;
            hold         <= '0;
            illegal_mode <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (accept) begin
                s2_valid <= 1'b1;
                s2_load  <= (mem_mode == MEM_LD);
                s2_first <= 1'b1;
                s2_sel   <= read_sel;
                s2_alu   <= alu_result;
            end else if (s2_valid) begin
                if (wb_ready) begin
                    s2_valid <= 1'b0;
                end else begin
                    s2_first <= 1'b0;
                    if (s2_first && s2_load)
                        hold <= rdata_sel;
                end
            end
            if (accept && is_illegal(mem_mode))
                illegal_mode <= 1'b1;
        end
    end

`ifdef DSP_MEM_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_stalls <= '0;
        end else begin
            if (accept && mem_mode == MEM_LD && perf_loads != 16'hFFFF)
                perf_loads <= perf_loads + 16'd1;
            if (accept && mem_mode == MEM_ST && perf_stores != 16'hFFFF)
                perf_stores <= perf_stores + 16'd1;
            if (s2_valid && !wb_ready && perf_stalls != 16'hFFFF)
                perf_stalls <= perf_stalls + 16'd1;
        end
    end
`endif

endmodule
